// File: rtl/fft16_ctrl.sv
// rtl/fft16_ctrl.sv - 16-point radix-2 DIF butterfly sequencer with frame buffer
module fft16_ctrl #(
  parameter int N    = 16,
  parameter int LOGN = 4,
  parameter int DW   = 32,
  parameter int TW   = 20
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [DW-1:0]   in_data,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [DW-1:0]   out_data,
  output logic [LOGN-1:0] out_index,
  output logic            busy,
  output logic            done,
  output logic [DW-1:0]   pu_x,
  output logic [DW-1:0]   pu_y,
  output logic [TW-1:0]   pu_w_real,
  output logic [TW-1:0]   pu_w_image,
  input  logic [DW-1:0]   pu_a,
  input  logic [DW-1:0]   pu_b
);

  typedef enum logic [1:0] {IDLE, LOAD, CALC, OUT} state_t;

  state_t          state_q, state_d;
  logic [LOGN-1:0] cnt_q, cnt_d;
  logic [4:0]      step_q, step_d;
  logic [LOGN-1:0] bin_q, bin_d;
  logic            done_q, done_d;
  logic [DW-1:0]   buf_q [N];
  logic [DW-1:0]   buf_d [N];

  logic [1:0]        s;
  logic [2:0]        k;
  logic [3:0]        u, l;
  logic [2:0]        t;
  logic signed [TW-1:0] tw_re, tw_im;
  logic [3:0]        bin_rev;
  logic              load_ready;

  assign s       = step_q[4:3];
  assign k       = step_q[2:0];
  assign bin_rev = {bin_q[0], bin_q[1], bin_q[2], bin_q[3]};
  assign done    = done_q;
  // in_ready must read 0 while rst is held, even though the state is already IDLE
  assign in_ready = load_ready & ~rst;

  // Butterfly operand addresses and twiddle index for stage s, butterfly k
  always_comb begin
    u = 4'd0;
    t = 3'd0;
    case (s)
      2'd0: begin u = {1'b0, k};               t = k;                end
      2'd1: begin u = {k[2], 1'b0, k[1:0]};    t = {k[1:0], 1'b0};   end
      2'd2: begin u = {k[2:1], 1'b0, k[0]};    t = {k[0], 2'b00};    end
      default: begin u = {k, 1'b0};            t = 3'd0;             end
    endcase
    l = u | (4'd8 >> s);
  end

  // Twiddle ROM: W(t) = exp(-j*2*pi*t/16) in signed Q16
  always_comb begin
    tw_re = 20'sd0;
    tw_im = 20'sd0;
    case (t)
      3'd0: begin tw_re =  20'sd65536; tw_im =  20'sd0;     end
      3'd1: begin tw_re =  20'sd60547; tw_im = -20'sd25080; end
      3'd2: begin tw_re =  20'sd46341; tw_im = -20'sd46341; end
      3'd3: begin tw_re =  20'sd25080; tw_im = -20'sd60547; end
      3'd4: begin tw_re =  20'sd0;     tw_im = -20'sd65536; end
      3'd5: begin tw_re = -20'sd25080; tw_im = -20'sd60547; end
      3'd6: begin tw_re = -20'sd46341; tw_im = -20'sd46341; end
      default: begin tw_re = -20'sd60547; tw_im = -20'sd25080; end
    endcase
  end

  // Processing-unit operands, forced to zero outside CALC
  always_comb begin
    pu_x       = '0;
    pu_y       = '0;
    pu_w_real  = '0;
    pu_w_image = '0;
    if (state_q == CALC) begin
      pu_x       = buf_q[u];
      pu_y       = buf_q[l];
      pu_w_real  = tw_re;
      pu_w_image = tw_im;
    end
  end

  // Status and output-stream drive decoded from the current state
  always_comb begin
    load_ready = 1'b0;
    busy       = 1'b0;
    out_valid  = 1'b0;
    out_data   = '0;
    out_index  = '0;
    case (state_q)
      IDLE, LOAD: load_ready = 1'b1;
      CALC:       busy = 1'b1;
      OUT: begin
        out_valid = 1'b1;
        out_data  = buf_q[bin_rev];
        out_index = bin_q;
      end
      default: ;
    endcase
  end

  // Next-state, counters and buffer write-back
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    step_d  = step_q;
    bin_d   = bin_q;
    done_d  = 1'b0;
    buf_d   = buf_q;
    case (state_q)
      IDLE, LOAD: begin
        if (state_q == IDLE) state_d = LOAD;
        if (in_valid) begin
          buf_d[cnt_q] = in_data;
          cnt_d        = cnt_q + 4'd1;
          if (cnt_q == 4'd15) begin
            state_d = CALC;
            step_d  = 5'd0;
          end
        end
      end
      CALC: begin
        buf_d[u] = pu_a;
        buf_d[l] = pu_b;
        step_d   = step_q + 5'd1;
        if (step_q == 5'd31) begin
          state_d = OUT;
          bin_d   = 4'd0;
        end
      end
      OUT: begin
        if (out_ready) begin
          bin_d = bin_q + 4'd1;
          if (bin_q == 4'd15) begin
            state_d = IDLE;
            done_d  = 1'b1;
            cnt_d   = 4'd0;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Control registers, cleared asynchronously so a reset aborts the frame at once
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      step_q  <= '0;
      bin_q   <= '0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      step_q  <= step_d;
      bin_q   <= bin_d;
      done_q  <= done_d;
    end
  end

  // Frame buffer: contents are don't-care after reset, so it has none
  always_ff @(posedge clk) begin
    buf_q <= buf_d;
  end

endmodule

// File: tb/tb_fft16_ctrl.sv
// tb/tb_fft16_ctrl.sv - bench for fft16_ctrl with butterfly model and DFT reference
module tb_fft16_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] in_data;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_data;
  logic [3:0]  out_index;
  logic        busy;
  logic        done;
  logic [31:0] pu_x, pu_y, pu_a, pu_b;
  logic [19:0] pu_w_real, pu_w_image;

  int errors = 0;
  int checks = 0;

  int fr_re [16];
  int fr_im [16];
  int res_re [16];
  int res_im [16];
  int tone_re [16];
  int tone_im [16];

  always #5 clk = ~clk;

  fft16_ctrl dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data), .out_index(out_index),
    .busy(busy), .done(done),
    .pu_x(pu_x), .pu_y(pu_y), .pu_w_real(pu_w_real), .pu_w_image(pu_w_image),
    .pu_a(pu_a), .pu_b(pu_b)
  );

  // Butterfly processing unit: a = X+Y, b = (X-Y)*W rounded to nearest, Q16 twiddle
  longint xr, xi, yr, yi, dr, di, wr, wi, ar, ai, prr, pri, br, bi;
  always_comb begin
    xr  = longint'($signed(pu_x[31:16]));
    xi  = longint'($signed(pu_x[15:0]));
    yr  = longint'($signed(pu_y[31:16]));
    yi  = longint'($signed(pu_y[15:0]));
    wr  = longint'($signed(pu_w_real));
    wi  = longint'($signed(pu_w_image));
    ar  = xr + yr;
    ai  = xi + yi;
    dr  = xr - yr;
    di  = xi - yi;
    prr = dr * wr - di * wi;
    pri = dr * wi + di * wr;
    br  = (prr + 64'sd32768) >>> 16;
    bi  = (pri + 64'sd32768) >>> 16;
    pu_a = {ar[15:0], ai[15:0]};
    pu_b = {br[15:0], bi[15:0]};
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input longint obs, input longint exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic chk_tol(input string tag, input int obs, input real exp, input int tol);
    real d;
    d = real'(obs) - exp;
    if (d < 0.0) d = -d;
    checks++;
    assert (d <= real'(tol))
    else begin
      errors++;
      $error("FAIL %s: got %0d expected %0.2f +/- %0d", tag, obs, exp, tol);
    end
  endtask

  task automatic feed(input bit gaps, output int ready_cycles);
    int  i;
    int  cyc;
    bit  acc;
    i = 0;
    cyc = 0;
    ready_cycles = 0;
    while (i < 16 && cyc < 2000) begin
      in_valid = gaps ? ($urandom_range(0, 2) != 0) : 1'b1;
      in_data  = {fr_re[i][15:0], fr_im[i][15:0]};
      if (in_ready) ready_cycles++;
      acc = in_valid && in_ready;
      step();
      if (acc) i++;
      cyc++;
    end
    in_valid = 1'b0;
    in_data  = '0;
    chk("feed_count", i, 16);
  endtask

  task automatic run_calc(output int busy_cycles);
    busy_cycles = 0;
    while (busy && busy_cycles < 200) begin
      busy_cycles++;
      step();
    end
  endtask

  task automatic collect(input bit stall, output int out_cycles);
    int          m;
    int          cyc;
    int          done_cnt;
    bit          stalled;
    logic [31:0] pd;
    logic [3:0]  pidx;
    m = 0;
    cyc = 0;
    done_cnt = 0;
    stalled = 1'b0;
    pd = '0;
    pidx = '0;
    out_cycles = 0;
    for (int b = 0; b < 16; b++) begin
      res_re[b] = 99999;
      res_im[b] = 99999;
    end
    while (m < 16 && cyc < 2000) begin
      if (stalled) begin
        chk("hold_data", out_data, pd);
        chk("hold_index", out_index, pidx);
      end
      out_ready = stall ? 1'($urandom_range(0, 1)) : 1'b1;
      if (done) done_cnt++;
      if (out_valid) out_cycles++;
      stalled = out_valid && !out_ready;
      pd = out_data;
      pidx = out_index;
      if (out_valid && out_ready) begin
        chk("out_index_order", out_index, m);
        res_re[out_index] = int'($signed(out_data[31:16]));
        res_im[out_index] = int'($signed(out_data[15:0]));
        m++;
      end
      step();
      cyc++;
    end
    out_ready = 1'b0;
    chk("out_count", m, 16);
    chk("done_early", done_cnt, 0);
    chk("done_pulse", done, 1);
    step();
    chk("done_clear", done, 0);
  endtask

  task automatic compare(input string tag, input int tol);
    real rr, ri, ang;
    for (int m = 0; m < 16; m++) begin
      rr = 0.0;
      ri = 0.0;
      for (int n = 0; n < 16; n++) begin
        ang = 6.283185307179586 * real'(m * n) / 16.0;
        rr = rr + real'(fr_re[n]) * $cos(ang) + real'(fr_im[n]) * $sin(ang);
        ri = ri + real'(fr_im[n]) * $cos(ang) - real'(fr_re[n]) * $sin(ang);
      end
      chk_tol($sformatf("%s_re%0d", tag, m), res_re[m], rr, tol);
      chk_tol($sformatf("%s_im%0d", tag, m), res_im[m], ri, tol);
    end
  endtask

  task automatic set_impulse();
    for (int n = 0; n < 16; n++) begin
      fr_re[n] = (n == 0) ? 256 : 0;
      fr_im[n] = 0;
    end
  endtask

  task automatic set_tone();
    for (int n = 0; n < 16; n++) begin
      fr_re[n] = int'(1000.0 * $cos(6.283185307179586 * real'(n) / 16.0));
      fr_im[n] = 0;
    end
  endtask

  int rc, bc, oc;

  initial begin
    rst = 1'b1;
    in_valid = 1'b0;
    in_data = '0;
    out_ready = 1'b0;
    #12;
    chk("rst_in_ready", in_ready, 0);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_out_data", out_data, 0);
    chk("rst_out_index", out_index, 0);
    chk("rst_pu_x", pu_x, 0);
    chk("rst_pu_y", pu_y, 0);
    chk("rst_pu_w_real", pu_w_real, 0);
    chk("rst_pu_w_image", pu_w_image, 0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    #1;
    chk("idle_in_ready", in_ready, 1);

    // Impulse frame with full timing checks
    set_impulse();
    feed(1'b0, rc);
    chk("ready_cycles", rc, 16);
    chk("calc_busy_start", busy, 1);
    chk("calc_in_ready", in_ready, 0);
    run_calc(bc);
    chk("busy_cycles", bc, 32);
    chk("first_out_valid", out_valid, 1);
    collect(1'b0, oc);
    chk("out_cycles", oc, 16);
    compare("impulse", 1);

    // DC frame
    for (int n = 0; n < 16; n++) begin
      fr_re[n] = 100;
      fr_im[n] = 0;
    end
    feed(1'b0, rc);
    run_calc(bc);
    chk("dc_busy_cycles", bc, 32);
    collect(1'b0, oc);
    compare("dc", 1);
    chk("dc_bin0_re", res_re[0], 1600);

    // Single tone at bin 1
    set_tone();
    feed(1'b0, rc);
    run_calc(bc);
    collect(1'b0, oc);
    compare("tone", 4);
    chk_tol("tone_bin1", res_re[1], 8000.0, 4);
    chk_tol("tone_bin15", res_re[15], 8000.0, 4);
    for (int b = 0; b < 16; b++) begin
      tone_re[b] = res_re[b];
      tone_im[b] = res_im[b];
    end

    // Same tone with input gaps and output backpressure
    feed(1'b1, rc);
    run_calc(bc);
    chk("gap_busy_cycles", bc, 32);
    collect(1'b1, oc);
    for (int b = 0; b < 16; b++) begin
      chk($sformatf("gap_same_re%0d", b), res_re[b], tone_re[b]);
      chk($sformatf("gap_same_im%0d", b), res_im[b], tone_im[b]);
    end

    // Random frames against the DFT reference
    for (int f = 0; f < 3; f++) begin
      for (int n = 0; n < 16; n++) begin
        fr_re[n] = int'($urandom_range(0, 4094)) - 2047;
        fr_im[n] = int'($urandom_range(0, 4094)) - 2047;
      end
      in_data = '0;
      feed(f[0], rc);
      run_calc(bc);
      collect(f[0], oc);
      compare($sformatf("rand%0d", f), 16);
    end

    // Reset in the middle of CALC, then a clean impulse frame
    set_impulse();
    feed(1'b0, rc);
    for (int c = 0; c < 10; c++) step();
    chk("mid_calc_busy", busy, 1);
    rst = 1'b1;
    #1;
    chk("abort_busy", busy, 0);
    chk("abort_in_ready", in_ready, 0);
    chk("abort_out_valid", out_valid, 0);
    chk("abort_done", done, 0);
    chk("abort_out_data", out_data, 0);
    chk("abort_pu_x", pu_x, 0);
    chk("abort_pu_y", pu_y, 0);
    chk("abort_pu_w_real", pu_w_real, 0);
    chk("abort_pu_w_image", pu_w_image, 0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    #1;
    chk("post_rst_in_ready", in_ready, 1);
    chk("post_rst_busy", busy, 0);
    feed(1'b0, rc);
    chk("post_rst_ready_cycles", rc, 16);
    run_calc(bc);
    chk("post_rst_busy_cycles", bc, 32);
    collect(1'b0, oc);
    compare("post_rst_impulse", 1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
